// File: rtl/time_counter_gen_pkg.sv
// Shared mode encodings, field limits and helpers for the TIME core.
// The M1_*/M2_* values mirror the encodings of the legacy clock share file.
package time_counter_gen_pkg;

  localparam logic [1:0] M1_TIME      = 2'd0;
  localparam logic [1:0] M1_DATE      = 2'd1;
  localparam logic [1:0] M1_ALARM     = 2'd2;
  localparam logic [1:0] M1_STOPW     = 2'd3;

  localparam logic [1:0] M2_TIME_G    = 2'd0;
  localparam logic [1:0] M2_TIME_HOUR = 2'd1;
  localparam logic [1:0] M2_TIME_MIN  = 2'd2;
  localparam logic [1:0] M2_TIME_SEC  = 2'd3;

  localparam logic [4:0] HOURS_MAX    = 5'd23;
  localparam logic [5:0] MINSEC_MAX   = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } key_state_e;

  // Wrapping single step of a field; no carry leaves the field.
  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] maxv,
                                           input logic up, input logic dn);
    logic [5:0] r;
    if (up) begin
      r = (v == maxv) ? 6'd0 : v + 6'd1;
    end else if (dn) begin
      r = (v == 6'd0) ? maxv : v - 6'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [4:0] hour_to_12(input logic [4:0] h);
    logic [4:0] r;
    if (h == 5'd0) begin
      r = 5'd12;
    end else if (h > 5'd12) begin
      r = h - 5'd12;
    end else begin
      r = h;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_counter_gen_if.sv
// Control inputs and time/display outputs of the TIME core.
interface time_counter_gen_if;
  logic       increase;
  logic       decrease;
  logic [1:0] mode1;
  logic [1:0] mode2;
  logic       fmt12;
  logic [4:0] hours;
  logic [4:0] disp_hours;
  logic       pm;
  logic [5:0] mins;
  logic [5:0] secs;
  logic       hour_carry;
  logic       sec_tick;

  modport master (
    output increase, decrease, mode1, mode2, fmt12,
    input  hours, disp_hours, pm, mins, secs, hour_carry, sec_tick
  );

  modport slave (
    input  increase, decrease, mode1, mode2, fmt12,
    output hours, disp_hours, pm, mins, secs, hour_carry, sec_tick
  );
endinterface

// File: rtl/time_key_repeat.sv
// Step-key FSM: one step on press, then auto-repeat after a hold delay.
// A direction change locks the keys until a no-request cycle is seen.
module time_key_repeat
  import time_counter_gen_pkg::*;
#(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic set_mode_i,
  input  logic req_up_i,
  input  logic req_dn_i,
  output logic step_up_o,
  output logic step_dn_o
);

  localparam int MAXV  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W = (MAXV < 2) ? 1 : $clog2(MAXV);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic             lock_q, lock_d;
  logic             req_s, dir_up_s, step_s;

  assign req_s    = req_up_i ^ req_dn_i;
  assign dir_up_s = req_up_i;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dir_up_q <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      lock_q   <= lock_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    lock_d   = lock_q;
    step_s   = 1'b0;
    if (!req_s) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      lock_d  = 1'b0;
    end else if (!set_mode_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if ((state_q != ST_IDLE) && (dir_up_s != dir_up_q)) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      lock_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (lock_q) begin
            state_d = ST_IDLE;
          end else begin
            step_s   = 1'b1;
            cnt_d    = '0;
            dir_up_d = dir_up_s;
            state_d  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (REPEAT_DELAY == 0) begin
            cnt_d = '0;
          end else if (cnt_q == RD_LAST) begin
            step_s  = 1'b1;
            cnt_d   = '0;
            state_d = ST_RPT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RPT: begin
          if (cnt_q == RR_LAST) begin
            step_s = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    step_up_o = step_s & dir_up_s;
    step_dn_o = step_s & ~dir_up_s;
  end

endmodule

// File: rtl/time_counter_gen.sv
// TIME core: second prescaler, hh:mm:ss counters with run carry chain,
// set-mode field stepping and 12/24-hour display decode.
module time_counter_gen
  import time_counter_gen_pkg::*;
#(
  parameter int CLOCKS4SEC   = 100,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  time_counter_gen_if.slave bus
);

  localparam int PRE_W = $clog2(CLOCKS4SEC);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLOCKS4SEC - 1);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [4:0]       hours_q, hours_d;
  logic [5:0]       mins_q, mins_d;
  logic [5:0]       secs_q, secs_d;
  logic             sec_tick_q, sec_tick_d;
  logic             hour_carry_q, hour_carry_d;
  logic             set_mode_s, step_up_s, step_dn_s;

  assign set_mode_s = (bus.mode1 == M1_TIME) && (bus.mode2 != M2_TIME_G);

  time_key_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_key (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_mode_i(set_mode_s),
    .req_up_i  (bus.increase),
    .req_dn_i  (bus.decrease),
    .step_up_o (step_up_s),
    .step_dn_o (step_dn_s)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q      <= '0;
      hours_q      <= 5'd0;
      mins_q       <= 6'd0;
      secs_q       <= 6'd0;
      sec_tick_q   <= 1'b0;
      hour_carry_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      hours_q      <= hours_d;
      mins_q       <= mins_d;
      secs_q       <= secs_d;
      sec_tick_q   <= sec_tick_d;
      hour_carry_q <= hour_carry_d;
    end
  end

  always_comb begin
    presc_d      = presc_q;
    hours_d      = hours_q;
    mins_d       = mins_q;
    secs_d       = secs_q;
    sec_tick_d   = 1'b0;
    hour_carry_d = 1'b0;
    if (set_mode_s) begin
      // Time is frozen while setting; only the selected field may step.
      presc_d = '0;
      case (bus.mode2)
        M2_TIME_HOUR: hours_d = 5'(step_wrap({1'b0, hours_q}, {1'b0, HOURS_MAX}, step_up_s, step_dn_s));
        M2_TIME_MIN:  mins_d  = step_wrap(mins_q, MINSEC_MAX, step_up_s, step_dn_s);
        M2_TIME_SEC:  secs_d  = step_wrap(secs_q, MINSEC_MAX, step_up_s, step_dn_s);
        default:      presc_d = '0;
      endcase
    end else if (presc_q == PRE_LAST) begin
      presc_d    = '0;
      sec_tick_d = 1'b1;
      if (secs_q == MINSEC_MAX) begin
        secs_d = 6'd0;
        if (mins_q == MINSEC_MAX) begin
          mins_d = 6'd0;
          if (hours_q == HOURS_MAX) begin
            hours_d      = 5'd0;
            hour_carry_d = 1'b1;
          end else begin
            hours_d = hours_q + 5'd1;
          end
        end else begin
          mins_d = mins_q + 6'd1;
        end
      end else begin
        secs_d = secs_q + 6'd1;
      end
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
  end

  assign bus.hours      = hours_q;
  assign bus.mins       = mins_q;
  assign bus.secs       = secs_q;
  assign bus.sec_tick   = sec_tick_q;
  assign bus.hour_carry = hour_carry_q;
  assign bus.disp_hours = bus.fmt12 ? hour_to_12(hours_q) : hours_q;
  assign bus.pm         = bus.fmt12 & (hours_q >= 5'd12);

endmodule

// File: tb/tb_time_counter_gen.sv
// Directed bench for time_counter_gen with a 10-clock second, delay 5, rate 2.
module tb_time_counter_gen;
  import time_counter_gen_pkg::*;

  localparam int C = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  time_counter_gen_if bus();

  time_counter_gen #(.CLOCKS4SEC(C), .REPEAT_DELAY(5), .REPEAT_RATE(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input logic [1:0] m1, input logic [1:0] m2);
    bus.mode1 = m1;
    bus.mode2 = m2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic pulse(input logic up, input logic dn);
    bus.increase = up;
    bus.decrease = dn;
    tick(1);
    bus.increase = 1'b0;
    bus.decrease = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    set_mode(M1_TIME, M2_TIME_G);
    bus.fmt12 = 1'b1;
    do_reset();
    tick(25);
    vectors++; if (bus.secs !== 6'd2) begin miscompares++; $display("FAIL pre_reset_secs: got %0d expected 2", bus.secs); end
    reset_n = 1'b0;
    tick(2);
    vectors++; if (bus.hours !== 5'd0) begin miscompares++; $display("FAIL reset_hours: got %0d expected 0", bus.hours); end
    vectors++; if (bus.mins !== 6'd0) begin miscompares++; $display("FAIL reset_mins: got %0d expected 0", bus.mins); end
    vectors++; if (bus.secs !== 6'd0) begin miscompares++; $display("FAIL reset_secs: got %0d expected 0", bus.secs); end
    vectors++; if (bus.hour_carry !== 1'b0) begin miscompares++; $display("FAIL reset_carry: got %0d expected 0", bus.hour_carry); end
    vectors++; if (bus.sec_tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %0d expected 0", bus.sec_tick); end
    vectors++; if (bus.disp_hours !== 5'd12) begin miscompares++; $display("FAIL reset_disp: got %0d expected 12", bus.disp_hours); end
    vectors++; if (bus.pm !== 1'b0) begin miscompares++; $display("FAIL reset_pm: got %0d expected 0", bus.pm); end
    reset_n = 1'b1;
    tick(C - 1);
    vectors++; if (bus.secs !== 6'd0) begin miscompares++; $display("FAIL first_sec_early: got %0d expected 0", bus.secs); end
    tick(1);
    vectors++; if (bus.secs !== 6'd1) begin miscompares++; $display("FAIL first_sec: got %0d expected 1", bus.secs); end
    vectors++; if (bus.sec_tick !== 1'b1) begin miscompares++; $display("FAIL first_tick: got %0d expected 1", bus.sec_tick); end
    #3 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick(C - 1);
    vectors++; if (bus.secs !== 6'd1) begin miscompares++; $display("FAIL glitch_hold: got %0d expected 1", bus.secs); end
    vectors++; if (bus.sec_tick !== 1'b0) begin miscompares++; $display("FAIL glitch_tick: got %0d expected 0", bus.sec_tick); end
    tick(1);
    vectors++; if (bus.secs !== 6'd2) begin miscompares++; $display("FAIL glitch_next: got %0d expected 2", bus.secs); end
  endtask

  task automatic test_decrease_wrap();
    set_mode(M1_TIME, M2_TIME_MIN);
    do_reset();
    pulse(1'b0, 1'b1);
    vectors++; if (bus.mins !== 6'd59) begin miscompares++; $display("FAIL dec_mins: got %0d expected 59", bus.mins); end
    vectors++; if (bus.hours !== 5'd0) begin miscompares++; $display("FAIL dec_mins_hours: got %0d expected 0", bus.hours); end
    vectors++; if (bus.secs !== 6'd0) begin miscompares++; $display("FAIL dec_mins_secs: got %0d expected 0", bus.secs); end
    vectors++; if (bus.hour_carry !== 1'b0) begin miscompares++; $display("FAIL dec_carry: got %0d expected 0", bus.hour_carry); end
    set_mode(M1_TIME, M2_TIME_HOUR);
    pulse(1'b0, 1'b1);
    vectors++; if (bus.hours !== 5'd23) begin miscompares++; $display("FAIL dec_hours: got %0d expected 23", bus.hours); end
    vectors++; if (bus.mins !== 6'd59) begin miscompares++; $display("FAIL dec_hours_mins: got %0d expected 59", bus.mins); end
  endtask

  task automatic test_rollover();
    set_mode(M1_TIME, M2_TIME_HOUR);
    do_reset();
    pulse(1'b0, 1'b1);
    set_mode(M1_TIME, M2_TIME_MIN);
    pulse(1'b0, 1'b1);
    set_mode(M1_TIME, M2_TIME_SEC);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    vectors++; if ({bus.hours, bus.mins, bus.secs} !== {5'd23, 6'd59, 6'd58}) begin miscompares++; $display("FAIL set_235958: got %0d:%0d:%0d expected 23:59:58", bus.hours, bus.mins, bus.secs); end
    set_mode(M1_TIME, M2_TIME_G);
    tick(C - 1);
    vectors++; if (bus.secs !== 6'd58) begin miscompares++; $display("FAIL roll_early: got %0d expected 58", bus.secs); end
    vectors++; if (bus.sec_tick !== 1'b0) begin miscompares++; $display("FAIL roll_tick_early: got %0d expected 0", bus.sec_tick); end
    tick(1);
    vectors++; if (bus.secs !== 6'd59) begin miscompares++; $display("FAIL roll_59: got %0d expected 59", bus.secs); end
    vectors++; if (bus.sec_tick !== 1'b1) begin miscompares++; $display("FAIL roll_tick59: got %0d expected 1", bus.sec_tick); end
    tick(C - 1);
    vectors++; if (bus.hour_carry !== 1'b0 || bus.hours !== 5'd23) begin miscompares++; $display("FAIL roll_pre: got carry %0d hours %0d expected 0 23", bus.hour_carry, bus.hours); end
    tick(1);
    vectors++; if ({bus.hours, bus.mins, bus.secs} !== 17'd0) begin miscompares++; $display("FAIL roll_zero: got %0d:%0d:%0d expected 0:0:0", bus.hours, bus.mins, bus.secs); end
    vectors++; if (bus.hour_carry !== 1'b1) begin miscompares++; $display("FAIL roll_carry: got %0d expected 1", bus.hour_carry); end
    vectors++; if (bus.sec_tick !== 1'b1) begin miscompares++; $display("FAIL roll_tick0: got %0d expected 1", bus.sec_tick); end
    tick(1);
    vectors++; if (bus.hour_carry !== 1'b0) begin miscompares++; $display("FAIL roll_carry_end: got %0d expected 0", bus.hour_carry); end
    vectors++; if (bus.sec_tick !== 1'b0) begin miscompares++; $display("FAIL roll_tick_end: got %0d expected 0", bus.sec_tick); end
  endtask

  task automatic test_auto_repeat();
    logic [5:0] exp_secs [1:11];
    exp_secs = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd1, 6'd2, 6'd2, 6'd3, 6'd3, 6'd4, 6'd4};
    set_mode(M1_TIME, M2_TIME_SEC);
    do_reset();
    bus.increase = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick(1);
      vectors++; if (bus.secs !== exp_secs[i]) begin miscompares++; $display("FAIL repeat_clk%0d: got %0d expected %0d", i, bus.secs, exp_secs[i]); end
    end
    bus.increase = 1'b0;
    tick(3);
    vectors++; if (bus.secs !== 6'd4) begin miscompares++; $display("FAIL repeat_release: got %0d expected 4", bus.secs); end
    bus.increase = 1'b1;
    bus.decrease = 1'b1;
    tick(4);
    vectors++; if (bus.secs !== 6'd4) begin miscompares++; $display("FAIL both_keys: got %0d expected 4", bus.secs); end
    bus.decrease = 1'b0;
    tick(1);
    vectors++; if (bus.secs !== 6'd5) begin miscompares++; $display("FAIL up_after_both: got %0d expected 5", bus.secs); end
    bus.increase = 1'b0;
    bus.decrease = 1'b1;
    tick(2);
    vectors++; if (bus.secs !== 6'd5) begin miscompares++; $display("FAIL dir_change_locked: got %0d expected 5", bus.secs); end
    bus.decrease = 1'b0;
    tick(1);
    pulse(1'b0, 1'b1);
    vectors++; if (bus.secs !== 6'd4) begin miscompares++; $display("FAIL rearm_down: got %0d expected 4", bus.secs); end
  endtask

  task automatic test_freeze();
    set_mode(M1_TIME, M2_TIME_G);
    do_reset();
    tick(C + 3);
    set_mode(M1_TIME, M2_TIME_HOUR);
    tick(3 * C);
    vectors++; if (bus.secs !== 6'd1) begin miscompares++; $display("FAIL freeze_secs: got %0d expected 1", bus.secs); end
    vectors++; if (bus.sec_tick !== 1'b0) begin miscompares++; $display("FAIL freeze_tick: got %0d expected 0", bus.sec_tick); end
    set_mode(M1_TIME, M2_TIME_G);
    tick(C - 1);
    vectors++; if (bus.secs !== 6'd1) begin miscompares++; $display("FAIL resume_early: got %0d expected 1", bus.secs); end
    tick(1);
    vectors++; if (bus.secs !== 6'd2) begin miscompares++; $display("FAIL resume_sec: got %0d expected 2", bus.secs); end
  endtask

  task automatic test_fmt12();
    set_mode(M1_TIME, M2_TIME_HOUR);
    bus.fmt12 = 1'b1;
    do_reset();
    vectors++; if ({bus.disp_hours, bus.pm} !== {5'd12, 1'b0}) begin miscompares++; $display("FAIL h0_12h: got %0d/%0d expected 12/0", bus.disp_hours, bus.pm); end
    bus.fmt12 = 1'b0; #1;
    vectors++; if ({bus.disp_hours, bus.pm} !== {5'd0, 1'b0}) begin miscompares++; $display("FAIL h0_24h: got %0d/%0d expected 0/0", bus.disp_hours, bus.pm); end
    bus.fmt12 = 1'b1;
    repeat (11) pulse(1'b1, 1'b0);
    vectors++; if ({bus.disp_hours, bus.pm} !== {5'd11, 1'b0}) begin miscompares++; $display("FAIL h11_12h: got %0d/%0d expected 11/0", bus.disp_hours, bus.pm); end
    pulse(1'b1, 1'b0);
    vectors++; if ({bus.disp_hours, bus.pm} !== {5'd12, 1'b1}) begin miscompares++; $display("FAIL h12_12h: got %0d/%0d expected 12/1", bus.disp_hours, bus.pm); end
    pulse(1'b1, 1'b0);
    vectors++; if ({bus.disp_hours, bus.pm} !== {5'd1, 1'b1}) begin miscompares++; $display("FAIL h13_12h: got %0d/%0d expected 1/1", bus.disp_hours, bus.pm); end
    bus.fmt12 = 1'b0; #1;
    vectors++; if ({bus.disp_hours, bus.pm} !== {5'd13, 1'b0}) begin miscompares++; $display("FAIL h13_24h: got %0d/%0d expected 13/0", bus.disp_hours, bus.pm); end
    bus.fmt12 = 1'b1;
    do_reset();
    pulse(1'b0, 1'b1);
    vectors++; if ({bus.disp_hours, bus.pm} !== {5'd11, 1'b1}) begin miscompares++; $display("FAIL h23_12h: got %0d/%0d expected 11/1", bus.disp_hours, bus.pm); end
    bus.fmt12 = 1'b0; #1;
    vectors++; if ({bus.disp_hours, bus.pm} !== {5'd23, 1'b0}) begin miscompares++; $display("FAIL h23_24h: got %0d/%0d expected 23/0", bus.disp_hours, bus.pm); end
  endtask

  initial begin
    bus.increase = 1'b0;
    bus.decrease = 1'b0;
    bus.mode1    = M1_TIME;
    bus.mode2    = M2_TIME_G;
    bus.fmt12    = 1'b0;
    test_reset();
    test_decrease_wrap();
    test_rollover();
    test_auto_repeat();
    test_freeze();
    test_fmt12();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
